// File: rtl/led_pattern_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : led_pattern_gen_if
//  Description : Control and LED-drive bundle for one LED pattern engine.
//                The master side issues mode/speed/mode_load commands.
//                The slave side returns the LED drive and the step pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_pattern_gen_if #(
   parameter int NUM_LEDS = 8
);
   logic [1:0]          mode;
   logic [3:0]          speed;
   logic                mode_load;
   logic [NUM_LEDS-1:0] leds;
   logic                step;

   modport master (
      output mode,
      output speed,
      output mode_load,
      input  leds,
      input  step
   );

   modport slave (
      input  mode,
      input  speed,
      input  mode_load,
      output leds,
      output step
   );
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : led_pattern_gen
//  Description : LED-strip pattern engine for one PMOD strip. It produces
//                binary-count, bounce-scanner, breathe (PWM fade) and rotate
//                patterns at a programmable step rate, and applies a global
//                PWM brightness.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_gen #(
   parameter int NUM_LEDS   = 8,
   parameter int PRESCALE   = 524288,
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input wire               CLK_48,
   input wire               reset_n,
   led_pattern_gen_if.slave bus
);

   localparam int                    c_presc_w      = $clog2(PRESCALE);
   localparam logic [c_presc_w-1:0]  c_presc_last   = c_presc_w'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0]   c_dmax         = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0]   c_duty_zero    = {PWM_BITS{1'b0}};
   localparam logic [NUM_LEDS-1:0]   c_leds_off     = {NUM_LEDS{ACTIVE_LOW}};
   localparam logic [NUM_LEDS-1:0]   c_pat_zero     = {NUM_LEDS{1'b0}};
   localparam logic [NUM_LEDS-1:0]   c_pat_ones     = {NUM_LEDS{1'b1}};
   localparam logic [NUM_LEDS-1:0]   c_pat_bit0     = NUM_LEDS'(1);

   localparam logic [1:0]            c_mode_count   = 2'd0;
   localparam logic [1:0]            c_mode_scan    = 2'd1;
   localparam logic [1:0]            c_mode_breathe = 2'd2;
   localparam logic [1:0]            c_mode_rotate  = 2'd3;

   localparam logic                  c_dir_up       = 1'b0;
   localparam logic                  c_dir_down     = 1'b1;

   // State registers and their next values
   logic [c_presc_w-1:0] presc_q,   presc_d;
   logic [3:0]           div_q,     div_d;
   logic [1:0]           mode_q,    mode_d;
   logic [3:0]           speed_q,   speed_d;
   logic [NUM_LEDS-1:0]  pattern_q, pattern_d;
   logic                 dir_q,     dir_d;
   logic [PWM_BITS-1:0]  duty_q,    duty_d;
   logic [PWM_BITS-1:0]  pwm_q,     pwm_d;
   logic                 step_q,    step_d;
   logic [NUM_LEDS-1:0]  leds_q,    leds_d;

   // Decoded timing and per-mode helpers
   logic                 w_tick;
   logic                 w_adv;
   logic [NUM_LEDS-1:0]  w_scan_next;
   logic [PWM_BITS-1:0]  w_duty_next;
   logic                 w_pwm_on;
   logic [NUM_LEDS-1:0]  w_lit;

   // A tick landing on a mode_load cycle is dropped so the new pattern starts cleanly
   assign w_tick      = (presc_q == c_presc_last);
   assign w_adv       = w_tick && (div_q == speed_q) && !bus.mode_load;
   assign w_scan_next = (dir_q == c_dir_up) ? (pattern_q << 1) : (pattern_q >> 1);
   assign w_duty_next = (dir_q == c_dir_up) ? (duty_q + 1'b1) : (duty_q - 1'b1);
   assign w_pwm_on    = (duty_q == c_dmax) || (pwm_q < duty_q);
   assign w_lit       = pattern_q & {NUM_LEDS{w_pwm_on}};

   // State register: async assert, every field returns to its idle value
   always_ff @(posedge CLK_48 or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         div_q     <= '0;
         mode_q    <= c_mode_count;
         speed_q   <= '0;
         pattern_q <= c_pat_zero;
         dir_q     <= c_dir_up;
         duty_q    <= c_dmax;
         pwm_q     <= '0;
         step_q    <= 1'b0;
         leds_q    <= c_leds_off;
      end else begin
         presc_q   <= presc_d;
         div_q     <= div_d;
         mode_q    <= mode_d;
         speed_q   <= speed_d;
         pattern_q <= pattern_d;
         dir_q     <= dir_d;
         duty_q    <= duty_d;
         pwm_q     <= pwm_d;
         step_q    <= step_d;
         leds_q    <= leds_d;
      end
   end

   // Next state: mode_load restarts everything, otherwise advance timing and pattern
   always_comb begin
      presc_d   = presc_q;
      div_d     = div_q;
      mode_d    = mode_q;
      speed_d   = speed_q;
      pattern_d = pattern_q;
      dir_d     = dir_q;
      duty_d    = duty_q;
      pwm_d     = pwm_q + 1'b1;

      if (bus.mode_load) begin
         mode_d  = bus.mode;
         speed_d = bus.speed;
         presc_d = '0;
         div_d   = '0;
         dir_d   = c_dir_up;
         case (bus.mode)
            c_mode_count: begin
               pattern_d = c_pat_zero;
               duty_d    = c_dmax;
            end
            c_mode_breathe: begin
               pattern_d = c_pat_ones;
               duty_d    = c_duty_zero;
            end
            default: begin
               pattern_d = c_pat_bit0;
               duty_d    = c_dmax;
            end
         endcase
      end else begin
         presc_d = w_tick ? '0 : presc_q + 1'b1;
         if (w_tick) begin
            div_d = (div_q == speed_q) ? 4'd0 : div_q + 4'd1;
         end
         if (w_adv) begin
            case (mode_q)
               c_mode_count: begin
                  pattern_d = pattern_q + 1'b1;
                  duty_d    = c_dmax;
               end
               c_mode_scan: begin
                  // Direction flips as the lit bit lands on an end, so ends show once
                  pattern_d = w_scan_next;
                  duty_d    = c_dmax;
                  if (w_scan_next[NUM_LEDS-1]) begin
                     dir_d = c_dir_down;
                  end else if (w_scan_next[0]) begin
                     dir_d = c_dir_up;
                  end
               end
               c_mode_breathe: begin
                  // Same end-turn rule as the scanner, applied to brightness
                  pattern_d = c_pat_ones;
                  duty_d    = w_duty_next;
                  if (w_duty_next == c_dmax) begin
                     dir_d = c_dir_down;
                  end else if (w_duty_next == c_duty_zero) begin
                     dir_d = c_dir_up;
                  end
               end
               c_mode_rotate: begin
                  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                  duty_d    = c_dmax;
               end
               default: begin
                  pattern_d = pattern_q;
               end
            endcase
         end
      end
   end

   // Outputs: step follows adv by one cycle, LEDs are the PWM-gated pattern in pin polarity
   always_comb begin
      step_d = w_adv;
      leds_d = ACTIVE_LOW ? ~w_lit : w_lit;
   end

   assign bus.leds = leds_q;
   assign bus.step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen. A driver issues
//                mode_load commands and queues the expected step sequence
//                from a behavioural pattern model; a monitor pops one entry
//                per step pulse and checks step spacing, LED pattern and PWM
//                lit counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pattern_gen;

   localparam int N    = 4;
   localparam int PRE  = 4;
   localparam int PB   = 4;
   localparam int DMAX = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_busy = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_pattern_gen_if #(.NUM_LEDS(N)) bus();

   led_pattern_gen #(
      .NUM_LEDS  (N),
      .PRESCALE  (PRE),
      .PWM_BITS  (PB),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .CLK_48 (clk),
      .reset_n(rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [N-1:0]  pattern;
      logic [PB-1:0] duty;
      int            interval;
      bit            window;
   } exp_t;

   exp_t exp_q[$];

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Pattern state after k steps following a restart, straight from the mode rules
   function automatic exp_t model_step(input int md, input int k, input int spd);
      exp_t e;
      int   m;
      int   pos;
      e.interval = PRE * (spd + 1);
      e.window   = (md == 2);
      e.duty     = PB'(DMAX);
      e.pattern  = '0;
      case (md)
         0: e.pattern = N'(k % (1 << N));
         1: begin
            m   = k % (2 * (N - 1));
            pos = (m < N) ? m : 2 * (N - 1) - m;
            e.pattern = N'(1) << pos;
         end
         2: begin
            m = k % (2 * DMAX);
            e.duty    = PB'((m <= DMAX) ? m : 2 * DMAX - m);
            e.pattern = '1;
         end
         default: e.pattern = N'(1) << (k % N);
      endcase
      return e;
   endfunction

   function automatic logic [N-1:0] init_leds(input int md);
      logic [N-1:0] p;
      case (md)
         0:       p = '0;
         2:       p = '0;   // duty starts at 0: fully dark
         default: p = N'(1);
      endcase
      return ~p;
   endfunction

   task automatic push_run(input int md, input int spd, input int n);
      for (int k = 1; k <= n; k++) exp_q.push_back(model_step(md, k, spd));
   endtask

   task automatic wait_drain(input int budget);
      for (int t = 0; t < budget; t++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !mon_busy) return;
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d steps still pending, expected 0", exp_q.size());
      exp_q.delete();
   endtask

   task automatic do_load(input int md, input int spd, input int extra, input int n);
      logic [N-1:0] el;
      repeat (extra) @(posedge clk);
      #1;
      bus.mode      = 2'(md);
      bus.speed     = 4'(spd);
      bus.mode_load = 1'b1;
      push_run(md, spd, n);
      @(posedge clk);
      #1;
      bus.mode_load = 1'b0;
      bus.mode      = 2'($urandom);
      bus.speed     = 4'($urandom);
      @(posedge clk);
      #1;
      el = init_leds(md);
      check("leds_after_load", int'(bus.leds), int'(el));
   endtask

   // Monitor: one queue entry per observed step pulse
   initial begin
      exp_t         it;
      int           last;
      bit           have_last;
      int           cnt [N];
      logic [N-1:0] el;
      int           req;
      last      = 0;
      have_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_last = 1'b0;
            continue;
         end
         if (bus.mode_load) begin
            last      = cyc + 1;
            have_last = 1'b1;
         end
         if (bus.step) begin
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_step: got step=1 expected 0 (cycle %0d)", cyc);
            end else begin
               it = exp_q.pop_front();
               if (have_last) check("step_interval", cyc - last, it.interval);
               last      = cyc;
               have_last = 1'b1;
               @(negedge clk);
               if (!it.window) begin
                  el = ~it.pattern;
                  check("leds_pattern", int'(bus.leds), int'(el));
               end else begin
                  for (int i = 0; i < N; i++) cnt[i] = 0;
                  for (int w = 0; w < 16; w++) begin
                     if (w > 0) @(negedge clk);
                     for (int i = 0; i < N; i++) if (!bus.leds[i]) cnt[i]++;
                  end
                  for (int i = 0; i < N; i++) begin
                     req = it.pattern[i] ? ((int'(it.duty) == DMAX) ? 16 : int'(it.duty)) : 0;
                     check("pwm_lit_count", cnt[i], req);
                  end
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   // Driver
   initial begin
      int md;
      int spd;
      int n;
      bus.mode      = 2'd0;
      bus.speed     = 4'd0;
      bus.mode_load = 1'b0;

      // Asynchronous reset assertion before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("reset_leds", int'(bus.leds), 'hF);
      check("reset_step", int'(bus.step), 0);
      repeat (3) @(negedge clk);

      // Free-running count from 0, wraps after 15
      push_run(0, 0, 17);
      #2 rst_n = 1'b1;
      wait_drain(3000);

      // Scanner at full rate
      do_load(1, 0, 0, 8);
      wait_drain(3000);

      // Rotate, one step every 12 clocks
      do_load(3, 2, 0, 8);
      wait_drain(3000);

      // Breathe slowly enough for a full 16-clock PWM window per step
      do_load(2, 5, 0, 32);
      wait_drain(3000);

      // Load landing on a tick: that tick must be dropped
      do_load(1, 0, 0, 3);
      wait_drain(3000);
      do_load(0, 0, 1, 3);
      wait_drain(3000);

      // Randomised mode changes
      for (int r = 0; r < 8; r++) begin
         md  = int'($urandom_range(0, 3));
         spd = (md == 2) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         n   = (md == 2) ? int'($urandom_range(4, 8)) : int'($urandom_range(3, 12));
         do_load(md, spd, int'($urandom_range(0, 1)), n);
         wait_drain(3000);
      end

      // Reset mid-scan, landing while a step pulse is high
      do_load(1, 0, 0, 3);
      wait_drain(3000);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_leds", int'(bus.leds), 'hF);
      check("midreset_step", int'(bus.step), 0);
      repeat (2) @(negedge clk);
      push_run(0, 0, 5);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release_leds", int'(bus.leds), 'hF);
      wait_drain(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
